rr_index_arbiter: RTL and testbench

- Round-robin arbiter that turns a request vector into a registered binary grant index with a valid/ready handshake.
- Sits directly upstream of the one-hot decoder stage. GNT_IDX drives the decoder's IN, so one-hot select lines are produced only from an accepted, stable index.
- Guarantees fairness: after a requester is served, every other pending requester is served before it again.

---
 rtl/rr_arb_pkg.sv | 11 +
 rtl/rr_index_pick.sv | 41 ++++
 rtl/rr_index_arbiter.sv | 107 ++++++++++
 tb/tb_rr_index_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin index arbiter.
package rr_arb_pkg;

    typedef enum logic {IDLE, OFFER} rr_state_t;

    // Increment with explicit wrap so non-power-of-2 requester counts work.
    function automatic int wrap_inc(input int idx, input int limit);
        return (idx == limit) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_index_pick.sv
// Combinational round-robin pick: first set request bit at or after PTR,
// wrapping to bit 0. Uses a double-width vector whose low half keeps only
// bits >= PTR, so the lowest set bit of the whole vector is the answer.
module rr_index_pick #(
    parameter int EncodeWidth = 4,
    parameter int ReqWidth    = 2**EncodeWidth
) (
    input  logic [ReqWidth-1:0]    REQ,
    input  logic [EncodeWidth-1:0] PTR,
    output logic                   HIT,
    output logic [EncodeWidth-1:0] IDX
);

    localparam logic [EncodeWidth:0] ReqCount = (EncodeWidth+1)'(ReqWidth);

    logic [ReqWidth-1:0]   mask;
    logic [2*ReqWidth-1:0] dbl;
    logic [EncodeWidth:0]  pos;
    logic                  found;

    // Masked double-width lowest-set-bit search.
    always_comb begin
        mask  = '0;
        pos   = '0;
        found = 1'b0;
        for (int i = 0; i < ReqWidth; i++) begin
            mask[i] = (i >= int'(PTR));
        end
        dbl = {REQ, REQ & mask};
        for (int i = 0; i < 2*ReqWidth; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                pos   = (EncodeWidth+1)'(i);
            end
        end
    end

    assign HIT = |REQ;
    assign IDX = (pos >= ReqCount) ? EncodeWidth'(pos - ReqCount) : pos[EncodeWidth-1:0];

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter producing a registered binary grant index with a
// valid/ready handshake. Offers are sticky until accepted; a new index is
// loaded on the accepting edge so back-to-back grants have no bubble.
// Optional burst hold is enabled by defining RR_INDEX_ARBITER_LOCK_EN,
// which adds the LOCK input.
module rr_index_arbiter
    import rr_arb_pkg::*;
#(
    parameter int EncodeWidth = 4,
    parameter int ReqWidth    = 2**EncodeWidth
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [ReqWidth-1:0]    REQ,
`ifdef RR_INDEX_ARBITER_LOCK_EN
    input  logic                   LOCK,
`endif
    output logic                   GNT_VALID,
    input  logic                   GNT_READY,
    output logic [EncodeWidth-1:0] GNT_IDX,
    output logic                   BUSY
);

    generate
        if (ReqWidth < 2 || ReqWidth > 2**EncodeWidth) begin : g_bad_width
            $error("rr_index_arbiter: ReqWidth must be in 2..2**EncodeWidth");
        end
    endgenerate

    rr_state_t              state_q, state_d;
    logic [EncodeWidth-1:0] idx_q, idx_d;
    logic [EncodeWidth-1:0] ptr_q, ptr_d;
    logic [EncodeWidth-1:0] adv_ptr;
    logic [EncodeWidth-1:0] pick_ptr;
    logic [EncodeWidth-1:0] pick_idx;
    logic                   pick_hit;
    logic                   hs;
    logic                   hold;

    // Pointer after serving the current grant, wrapping at the last requester.
    assign adv_ptr = EncodeWidth'(wrap_inc(int'(idx_q), ReqWidth - 1));

`ifdef RR_INDEX_ARBITER_LOCK_EN
    assign hold = LOCK & REQ[idx_q];
`else
    assign hold = 1'b0;
`endif

    // While offering, the search only matters on a handshake, where it must
    // already use the advanced pointer; in IDLE it uses the stored pointer.
    assign pick_ptr = (state_q == OFFER) ? adv_ptr : ptr_q;
    assign hs       = (state_q == OFFER) & GNT_READY;

    rr_index_pick #(
        .EncodeWidth(EncodeWidth),
        .ReqWidth   (ReqWidth)
    ) u_pick (
        .REQ(REQ),
        .PTR(pick_ptr),
        .HIT(pick_hit),
        .IDX(pick_idx)
    );

    // Next-state: offer from IDLE, or advance/reload/retire on a handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    idx_d   = pick_idx;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (hs && !hold) begin
                    ptr_d = adv_ptr;
                    if (pick_hit) begin
                        idx_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any outstanding offer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign GNT_VALID = (state_q == OFFER);
    assign BUSY      = (state_q == OFFER);
    assign GNT_IDX   = idx_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Testbench for rr_index_arbiter: directed vector table, a ReqWidth=3
// wrap sequence, optional LOCK sequence and randomized model comparison.
module tb_rr_index_arbiter;

    localparam int EW  = 2;
    localparam int RW  = 4;
    localparam int RW3 = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [RW-1:0] req = '0;
    logic          rdy = 1'b0;
    logic          vld;
    logic [EW-1:0] idx;
    logic          busy;
    logic          lock = 1'b0;

    logic [RW3-1:0] req3 = '0;
    logic           rdy3 = 1'b0;
    logic           vld3;
    logic [EW-1:0]  idx3;
    logic           busy3;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    rr_index_arbiter #(.EncodeWidth(EW), .ReqWidth(RW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (req),
`ifdef RR_INDEX_ARBITER_LOCK_EN
        .LOCK     (lock),
`endif
        .GNT_VALID(vld),
        .GNT_READY(rdy),
        .GNT_IDX  (idx),
        .BUSY     (busy)
    );

    rr_index_arbiter #(.EncodeWidth(EW), .ReqWidth(RW3)) dut3 (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (req3),
`ifdef RR_INDEX_ARBITER_LOCK_EN
        .LOCK     (1'b0),
`endif
        .GNT_VALID(vld3),
        .GNT_READY(rdy3),
        .GNT_IDX  (idx3),
        .BUSY     (busy3)
    );

    typedef struct {
        logic          rst;
        logic [RW-1:0] req;
        logic          rdy;
        logic          exp_vld;
        int            exp_idx;
    } vec_t;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: pending offer, offered index, priority pointer.
    int m_vld, m_idx, m_ptr;

    function automatic int first_from(input logic [RW-1:0] r, input int start);
        for (int k = 0; k < RW; k++) begin
            if (r[(start + k) % RW]) return (start + k) % RW;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r_rst, input logic [RW-1:0] r, input logic ready);
        int f;
        if (r_rst) begin
            m_vld = 0; m_idx = 0; m_ptr = 0;
        end else if (m_vld == 0) begin
            f = first_from(r, m_ptr);
            if (f >= 0) begin m_vld = 1; m_idx = f; end
        end else if (ready) begin
            m_ptr = (m_idx + 1) % RW;
            f = first_from(r, m_ptr);
            if (f >= 0) m_idx = f;
            else m_vld = 0;
        end
    endtask

    vec_t vecs[$];

    initial begin
        // rst, req, rdy, exp_vld, exp_idx
        vecs.push_back('{1, 4'b1111, 1, 0, 0});
        vecs.push_back('{1, 4'b1111, 1, 0, 0});
        vecs.push_back('{1, 4'b1111, 1, 0, 0});
        vecs.push_back('{0, 4'b1111, 1, 1, 0});
        vecs.push_back('{0, 4'b1111, 1, 1, 1});
        vecs.push_back('{0, 4'b1111, 1, 1, 2});
        vecs.push_back('{0, 4'b1111, 1, 1, 3});
        vecs.push_back('{0, 4'b1111, 1, 1, 0});
        vecs.push_back('{0, 4'b0100, 1, 1, 2});
        vecs.push_back('{0, 4'b0100, 0, 1, 2});
        vecs.push_back('{0, 4'b0000, 0, 1, 2});
        vecs.push_back('{0, 4'b0000, 0, 1, 2});
        vecs.push_back('{0, 4'b0000, 0, 1, 2});
        vecs.push_back('{0, 4'b0000, 0, 1, 2});
        vecs.push_back('{0, 4'b0000, 1, 0, 2});
        vecs.push_back('{0, 4'b0000, 1, 0, 2});
        vecs.push_back('{0, 4'b1000, 0, 1, 3});
        vecs.push_back('{0, 4'b0110, 1, 1, 1});
        vecs.push_back('{0, 4'b0110, 1, 1, 2});
        vecs.push_back('{0, 4'b0110, 0, 1, 2});
        vecs.push_back('{1, 4'b0110, 0, 0, 0});
        vecs.push_back('{0, 4'b1100, 0, 1, 2});
        vecs.push_back('{0, 4'b1100, 1, 1, 3});
        vecs.push_back('{0, 4'b0000, 1, 0, 3});
        vecs.push_back('{0, 4'b0001, 0, 1, 0});
        vecs.push_back('{0, 4'b0001, 1, 1, 0});
        vecs.push_back('{0, 4'b0011, 1, 1, 1});
        vecs.push_back('{0, 4'b0011, 1, 1, 0});
        vecs.push_back('{0, 4'b0000, 1, 0, 0});

        #1;
        foreach (vecs[n]) begin
            RST = vecs[n].rst;
            req = vecs[n].req;
            rdy = vecs[n].rdy;
            tick();
            chk($sformatf("vec%0d_valid", n), int'(vld), int'(vecs[n].exp_vld));
            chk($sformatf("vec%0d_busy", n), int'(busy), int'(vecs[n].exp_vld));
            chk($sformatf("vec%0d_idx", n), int'(idx), vecs[n].exp_idx);
        end

        // ReqWidth=3: accepting idx 2 wraps to 0.
        RST = 1'b1; req = '0; rdy = 1'b0;
        tick();
        RST = 1'b0; req3 = 3'b111; rdy3 = 1'b1;
        begin
            int exp3[4] = '{0, 1, 2, 0};
            for (int k = 0; k < 4; k++) begin
                tick();
                chk($sformatf("rw3_valid%0d", k), int'(vld3), 1);
                chk($sformatf("rw3_idx%0d", k), int'(idx3), exp3[k]);
            end
        end
        req3 = '0;
        tick();
        tick();
        chk("rw3_idle", int'(vld3), 0);

`ifdef RR_INDEX_ARBITER_LOCK_EN
        RST = 1'b1; tick();
        RST = 1'b0; req = 4'b1010; lock = 1'b1; rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("lock_idx%0d", k), int'(idx), 1);
        end
        lock = 1'b0;
        tick();
        chk("unlock_idx", int'(idx), 3);
        chk("unlock_valid", int'(vld), 1);
        req = '0; tick(); tick();
`endif

        // Randomized comparison against the reference model.
        RST = 1'b1; req = '0; rdy = 1'b0; lock = 1'b0;
        model_edge(1'b1, '0, 1'b0);
        tick();
        RST = 1'b0;
        for (int c = 0; c < 400; c++) begin
            RST = ($urandom_range(0, 99) == 0);
            req = (($urandom_range(0, 3) == 0) ? '0 : RW'($urandom));
            rdy = ($urandom_range(0, 2) != 0);
            model_edge(RST, req, rdy);
            tick();
            chk($sformatf("rnd%0d_valid", c), int'(vld), m_vld);
            chk($sformatf("rnd%0d_busy", c), int'(busy), m_vld);
            chk($sformatf("rnd%0d_idx", c), int'(idx), m_idx);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
